bpm_averager: RTL and testbench



---
 rtl/bpm_averager.sv | 186 ++++++++++++++++++
 tb/tb_bpm_averager.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_averager.sv
// bpm_averager: accepts BPM samples from the calculator stage, discards
// out-of-range values and single-beat outliers, and keeps a circular window
// of accepted samples. Each accepted sample yields a rounded moving average
// on a valid/ready port.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | wait for a sample; capture only once the last average is taken
// CHECK  | range and outlier test on the captured sample
// UPDATE | write the sample into the window (or flush and restart it)
// OUTPUT | divide the running sum by fill_count and raise avg_valid
module bpm_averager #(
    parameter int DEPTH      = 4,
    parameter int MIN_BPM    = 30,
    parameter int MAX_BPM    = 220,
    parameter int JUMP       = 30,
    parameter int MAX_REJECT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [7:0]               bpm_value,
    input  logic                     bpm_valid,
    output logic                     bpm_copied,
    output logic [7:0]               avg_bpm,
    output logic                     avg_valid,
    input  logic                     avg_ready,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     beat_rejected
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam int SW = 8 + PW;
    localparam int NW = SW + 1;
    localparam int RW = $clog2(MAX_REJECT + 1);
    // Outliers seen so far below this count are rejected; reaching it flushes.
    localparam logic [RW-1:0] REJ_LIM = RW'(MAX_REJECT - 1);
    localparam logic [FW-1:0] FULL    = FW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CHECK, UPDATE, OUTPUT} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      sample_r;
    logic [7:0]      window [DEPTH];
    logic [SW-1:0]   sum_r;
    logic [PW-1:0]   wr_ptr;
    logic [RW-1:0]   reject_cnt;
    logic            flush_r;

    logic            capture;
    logic            range_fail;
    logic            outlier_rej;
    logic            force_flush;

    logic            in_range;
    logic            is_outlier;
    logic signed [8:0] diff;
    logic [8:0]      abs_diff;
    logic [SW-1:0]   oldest;
    logic [NW-1:0]   avg_num;

    assign in_range   = (sample_r >= 8'(MIN_BPM)) && (sample_r <= 8'(MAX_BPM));
    // The reference is the last published average, consumed or not.
    assign diff       = $signed({1'b0, sample_r}) - $signed({1'b0, avg_bpm});
    assign abs_diff   = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    assign is_outlier = (fill_count != '0) && (abs_diff > 9'(JUMP));
    // Once the window is full the entry at wr_ptr is the oldest one and drops out.
    assign oldest     = (fill_count == FULL) ? SW'(window[wr_ptr]) : '0;
    assign avg_num    = {1'b0, sum_r} + NW'(fill_count >> 1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        range_fail  = 1'b0;
        outlier_rej = 1'b0;
        force_flush = 1'b0;
        case (state)
            IDLE: begin
                if (en && bpm_valid && !avg_valid) begin
                    capture   = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!in_range) begin
                    range_fail = 1'b1;
                    state_nxt  = IDLE;
                end else if (is_outlier) begin
                    if (reject_cnt < REJ_LIM) begin
                        outlier_rej = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        force_flush = 1'b1;
                        state_nxt   = UPDATE;
                    end
                end else begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE:  state_nxt = OUTPUT;
            OUTPUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Upstream handshake, sample capture, reject pulse and outlier bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpm_copied    <= 1'b0;
            beat_rejected <= 1'b0;
            sample_r      <= '0;
            flush_r       <= 1'b0;
            reject_cnt    <= '0;
        end else begin
            bpm_copied    <= capture;
            beat_rejected <= range_fail | outlier_rej;
            if (capture) begin
                sample_r <= bpm_value;
            end
            if (state == CHECK) begin
                flush_r <= force_flush;
            end
            if (outlier_rej) begin
                reject_cnt <= reject_cnt + 1'b1;
            end else if (state == UPDATE) begin
                reject_cnt <= '0;
            end
        end
    end

    // Window, running sum, write pointer and fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                window[i] <= '0;
            end
            sum_r      <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
        end else if (state == UPDATE) begin
            if (flush_r) begin
                for (int i = 0; i < DEPTH; i++) begin
                    window[i] <= '0;
                end
                window[0]  <= sample_r;
                sum_r      <= SW'(sample_r);
                wr_ptr     <= PW'(1);
                fill_count <= FW'(1);
            end else begin
                window[wr_ptr] <= sample_r;
                wr_ptr         <= wr_ptr + 1'b1;
                sum_r          <= sum_r + SW'(sample_r) - oldest;
                if (fill_count != FULL) begin
                    fill_count <= fill_count + 1'b1;
                end
            end
        end
    end

    // Rounded average and the downstream valid/ready hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_bpm   <= '0;
            avg_valid <= 1'b0;
        end else if (state == OUTPUT) begin
            avg_bpm   <= 8'(avg_num / NW'(fill_count));
            avg_valid <= 1'b1;
        end else if (avg_valid && avg_ready) begin
            avg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpm_averager.sv
// Bench for bpm_averager: directed scenarios followed by random samples,
// compared against a queue-based window model.
module tb_bpm_averager;

    localparam int DEPTH      = 4;
    localparam int MIN_BPM    = 30;
    localparam int MAX_BPM    = 220;
    localparam int JUMP       = 30;
    localparam int MAX_REJECT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] bpm_value;
    logic       bpm_valid;
    logic       bpm_copied;
    logic [7:0] avg_bpm;
    logic       avg_valid;
    logic       avg_ready;
    logic [2:0] fill_count;
    logic       beat_rejected;

    int n_total = 0;
    int n_bad   = 0;

    int win[$];
    int mavg = 0;
    int mrej = 0;
    bit pend = 1'b0;

    bpm_averager #(
        .DEPTH(DEPTH), .MIN_BPM(MIN_BPM), .MAX_BPM(MAX_BPM),
        .JUMP(JUMP), .MAX_REJECT(MAX_REJECT)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .bpm_value(bpm_value), .bpm_valid(bpm_valid), .bpm_copied(bpm_copied),
        .avg_bpm(avg_bpm), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .fill_count(fill_count), .beat_rejected(beat_rejected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_avg();
        int s = 0;
        foreach (win[i]) s += win[i];
        return (s + win.size() / 2) / win.size();
    endfunction

    task automatic model_clear();
        win.delete();
        mavg = 0;
        mrej = 0;
        pend = 1'b0;
    endtask

    // Applies one captured sample to the model; acc says whether it is kept.
    task automatic model_step(input int v, output bit acc);
        int d;
        acc = 1'b0;
        if (v >= MIN_BPM && v <= MAX_BPM) begin
            d = (v > mavg) ? v - mavg : mavg - v;
            if (win.size() > 0 && d > JUMP) begin
                if (mrej + 1 < MAX_REJECT) begin
                    mrej++;
                end else begin
                    win.delete();
                    win.push_back(v);
                    mrej = 0;
                    acc  = 1'b1;
                end
            end else begin
                win.push_back(v);
                if (win.size() > DEPTH) void'(win.pop_front());
                mrej = 0;
                acc  = 1'b1;
            end
            if (acc) mavg = model_avg();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bpm_valid = 1'b0;
        en        = 1'b0;
        avg_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        model_clear();
    endtask

    // Offers one sample, follows it through CHECK/UPDATE/OUTPUT and checks
    // every visible output against the model along the way.
    task automatic send(input int v, input bit rdy, output int waited, output bit acc);
        bpm_value = 8'(v);
        bpm_valid = 1'b1;
        en        = 1'b1;
        avg_ready = rdy;
        waited    = 0;
        acc       = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            waited++;
            if (bpm_copied) break;
        end
        if (!bpm_copied) begin
            chk("capture_timeout", 0, 1);
            bpm_valid = 1'b0;
        end else begin
            bpm_valid = 1'b0;
            en = 1'($urandom_range(0, 1));
            model_step(v, acc);
            @(posedge clk);
            #1;
            chk("copied_pulse", int'(bpm_copied), 0);
            chk("beat_rejected", int'(beat_rejected), int'(!acc));
            chk("valid_at_check", int'(avg_valid), 0);
            @(posedge clk);
            #1;
            chk("valid_early", int'(avg_valid), 0);
            chk("reject_pulse_end", int'(beat_rejected), 0);
            if (acc) begin
                @(posedge clk);
                #1;
                chk("valid_latency", int'(avg_valid), 1);
            end
            chk("avg_bpm", int'(avg_bpm), mavg);
            chk("fill_count", int'(fill_count), win.size());
            if (acc && rdy) begin
                @(posedge clk);
                #1;
                chk("valid_clear", int'(avg_valid), 0);
            end
        end
        pend = acc && !rdy;
    endtask

    task automatic reset_mid(input int extra);
        int  w;
        bit  a;
        bpm_value = 8'd75;
        bpm_valid = 1'b1;
        en        = 1'b1;
        avg_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bpm_copied) break;
        end
        chk("mid_capture", int'(bpm_copied), 1);
        bpm_valid = 1'b0;
        repeat (extra) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_copied", int'(bpm_copied), 0);
        chk("rst_avg", int'(avg_bpm), 0);
        chk("rst_valid", int'(avg_valid), 0);
        chk("rst_fill", int'(fill_count), 0);
        chk("rst_rej", int'(beat_rejected), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("rst_no_output", int'(avg_valid), 0);
        end
        send(75, 1'b1, w, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit a;
        int v;
        int base;
        int ramp[5] = '{60, 62, 64, 66, 68};

        rst = 1'b1; en = 1'b0; bpm_valid = 1'b0; bpm_value = '0; avg_ready = 1'b1;
        #12;
        chk("reset_copied", int'(bpm_copied), 0);
        chk("reset_avg", int'(avg_bpm), 0);
        chk("reset_valid", int'(avg_valid), 0);
        chk("reset_fill", int'(fill_count), 0);
        chk("reset_rej", int'(beat_rejected), 0);
        #11 rst = 1'b0;
        model_clear();

        // Steady input.
        for (int i = 0; i < 4; i++) begin
            send(60, 1'b1, w, a);
            chk("steady_cap_lat", w, 1);
        end
        chk("steady_fill", int'(fill_count), 4);
        chk("steady_avg", int'(avg_bpm), 60);

        // Ramp and wrap of the window.
        do_reset();
        foreach (ramp[i]) send(ramp[i], 1'b1, w, a);
        chk("ramp_avg", int'(avg_bpm), 65);
        chk("ramp_fill", int'(fill_count), 4);

        // Outliers: two rejected, third flushes.
        do_reset();
        repeat (4) send(60, 1'b1, w, a);
        repeat (3) send(120, 1'b1, w, a);
        chk("flush_fill", int'(fill_count), 1);
        chk("flush_avg", int'(avg_bpm), 120);

        // Range limits.
        send(29, 1'b1, w, a);
        send(221, 1'b1, w, a);
        do_reset();
        send(30, 1'b1, w, a);
        chk("min_accepted", int'(fill_count), 1);
        send(220, 1'b1, w, a);
        do_reset();
        send(200, 1'b1, w, a);
        send(220, 1'b1, w, a);
        chk("max_accepted", int'(avg_bpm), 210);

        // Capture enable low holds the upstream sample.
        en = 1'b0; bpm_value = 8'd205; bpm_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("en_low_copied", int'(bpm_copied), 0);
        end
        send(205, 1'b1, w, a);
        chk("en_cap_lat", w, 1);

        // Backpressure.
        do_reset();
        send(80, 1'b0, w, a);
        bpm_value = 8'd90; bpm_valid = 1'b1; en = 1'b1; avg_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_copied", int'(bpm_copied), 0);
            chk("bp_valid_held", int'(avg_valid), 1);
            chk("bp_avg_held", int'(avg_bpm), 80);
        end
        send(90, 1'b1, w, a);
        chk("bp_cap_lat", w, 2);
        chk("bp_avg", int'(avg_bpm), 85);

        // Reset during CHECK, then during UPDATE.
        send(84, 1'b1, w, a);
        reset_mid(0);
        chk("post_rst_avg", int'(avg_bpm), 75);
        chk("post_rst_fill", int'(fill_count), 1);
        send(77, 1'b1, w, a);
        reset_mid(1);
        chk("post_rst2_avg", int'(avg_bpm), 75);

        // Random samples.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0: v = $urandom_range(0, MIN_BPM - 1);
                1: v = $urandom_range(MAX_BPM + 1, 255);
                2: v = $urandom_range(0, 255);
                default: begin
                    base = (win.size() > 0) ? mavg : 100;
                    v = base + int'($urandom_range(0, 70)) - 35;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                end
            endcase
            w = pend ? 2 : 1;
            base = w;
            send(v, pend ? 1'b1 : 1'($urandom_range(0, 1)), w, a);
            chk("rand_cap_lat", w, base);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
